// File: rtl/list_sum_engine_if.sv
// Memory read port bundle for list_sum_engine.
// The engine is the master (drives req/addr); the memory is the slave
// (returns ack/rdata, ack may arrive in the same cycle as req).
interface list_sum_engine_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/list_sum_engine.sv
// list_sum_engine: walks a singly linked list (value at p, next pointer at
// p+1) from head_addr_i, summing node values and counting nodes. A node-count
// guard stops walks on cyclic lists. Optional saturating sum is enabled by
// defining LIST_SUM_SAT_EN; otherwise the sum wraps and err reports only the
// loop guard.
module list_sum_engine #(
    parameter int DW = 8,
    parameter int AW = 8,
    parameter int SW = 16,
    parameter int CW = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [AW-1:0]            head_addr_i,
    list_sum_engine_if.master        mem,
    output logic [SW-1:0]            sum_o,
    output logic [CW-1:0]            node_cnt_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_VAL  = 2'd1,
        RD_NEXT = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

`ifdef LIST_SUM_SAT_EN
    localparam int            XW      = ((SW > DW) ? SW : DW) + 1;
    localparam logic [XW-1:0] SUM_MAX = {{(XW-SW){1'b0}}, {SW{1'b1}}};
`endif

    state_t        state_q;
    logic [AW-1:0] ptr_q;
    logic [SW-1:0] sum_q;
    logic [CW-1:0] cnt_q;
    logic          err_q;
    logic          req_q;
    logic [AW-1:0] addr_q;
    logic          busy_q;
    logic          done_q;

    // {overflow flag, new sum}; flag can only be set in saturating builds
    logic [SW:0]   sum_d;
    logic [AW-1:0] next_ptr;

    // Accumulate one node value into the running sum.
    function automatic logic [SW:0] acc_add(input logic [SW-1:0] s,
                                            input logic [DW-1:0] v);
`ifdef LIST_SUM_SAT_EN
        logic [XW-1:0] full;
        full = XW'(s) + XW'(v);
        if (full > SUM_MAX) begin
            return {1'b1, {SW{1'b1}}};
        end
        return {1'b0, full[SW-1:0]};
`else
        return {1'b0, s + SW'(v)};
`endif
    endfunction

    assign sum_d    = acc_add(sum_q, mem.mem_rdata);
    assign next_ptr = mem.mem_rdata[AW-1:0];

    // Walk controller and datapath; all outputs are registered alongside state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        ptr_q <= head_addr_i;
                        sum_q <= '0;
                        cnt_q <= '0;
                        err_q <= 1'b0;
                        if (head_addr_i != '0) begin
                            state_q <= RD_VAL;
                            req_q   <= 1'b1;
                            addr_q  <= head_addr_i;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                RD_VAL: begin
                    if (mem.mem_ack) begin
                        sum_q <= sum_d[SW-1:0];
                        if (sum_d[SW]) begin
                            err_q <= 1'b1;
                        end
                        cnt_q   <= cnt_q + 1'b1;
                        addr_q  <= ptr_q + 1'b1;    // wraps mod 2^AW
                        state_q <= RD_NEXT;
                    end
                end
                RD_NEXT: begin
                    if (mem.mem_ack) begin
                        ptr_q <= next_ptr;
                        if (next_ptr == '0 || cnt_q == CNT_MAX) begin
                            // End of list, or guard tripped on a too-long/cyclic list
                            if (next_ptr != '0) begin
                                err_q <= 1'b1;
                            end
                            state_q <= DONE;
                            req_q   <= 1'b0;
                            addr_q  <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RD_VAL;
                            addr_q  <= next_ptr;
                        end
                    end
                end
                DONE: begin
                    if (!start_i) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem.mem_req  = req_q;
    assign mem.mem_addr = addr_q;
    assign sum_o        = sum_q;
    assign node_cnt_o   = cnt_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule
